branch_history_table: RTL

Parametrised direct-mapped table of saturating branch-prediction counters, indexed by fetch PC. Optionally hashed with a global history register (gshare). Sits in the fetch stage: the fetch unit issues a lookup per branch and gets a registered taken/not-taken prediction one cycle later. The execute stage writes resolved outcomes back through a separate update port. It replaces the single fixed 2-bit predictor entry with a configurable table, adds history hashing, a flush, and same-cycle read/write bypass.

---
 rtl/branch_history_table.sv | 106 ++++++++++
 1 files changed

// File: rtl/branch_history_table.sv
// Direct-mapped table of saturating branch counters indexed by fetch PC,
// optionally XOR-hashed with a global history register (gshare).
module branch_history_table #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int ADDR_W  = 32,
  parameter int GHR_W   = 0,
  localparam int INDEX_W   = $clog2(ENTRIES),
  localparam int GHR_OUT_W = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 lookup_en,
  input  logic [ADDR_W-1:0]    lookup_pc,
  output logic                 predict_valid,
  output logic                 predict,
  output logic [INDEX_W-1:0]   predict_index,
  input  logic                 update_en,
  input  logic [INDEX_W-1:0]   update_index,
  input  logic                 update_taken,
  output logic [GHR_OUT_W-1:0] ghr
);

  localparam logic [CNT_W-1:0] INIT    = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  logic [CNT_W-1:0]   cnt [ENTRIES];
  logic [INDEX_W-1:0] ghr_ext;
  logic [CNT_W-1:0]   upd_cnt_p0;
  logic [CNT_W-1:0]   upd_val_p0;
  logic [INDEX_W-1:0] lkp_idx_p0;
  logic [CNT_W-1:0]   lkp_cnt_p0;
  logic               vld_p1;
  logic               pred_p1;
  logic [INDEX_W-1:0] idx_p1;
  logic               unused_pc;

  // Only PC[INDEX_W+1:2] selects an entry; the rest is deliberately ignored.
  assign unused_pc = ^lookup_pc;

  generate
    if (GHR_W > 0) begin : g_ghr
      logic [GHR_W-1:0] ghr_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ghr_q <= '0;
        end else if (flush) begin
          ghr_q <= '0;
        end else if (update_en) begin
          if (GHR_W == 1) ghr_q <= GHR_W'(update_taken);
          else            ghr_q <= GHR_W'({ghr_q, update_taken});
        end
      end

      assign ghr     = ghr_q;
      assign ghr_ext = INDEX_W'(ghr_q);
    end else begin : g_no_ghr
      assign ghr     = '0;
      assign ghr_ext = '0;
    end
  endgenerate

  // Stage p0: index hash, counter read and same-cycle update bypass.
  always_comb begin
    upd_cnt_p0 = cnt[update_index];
    upd_val_p0 = update_taken ? sat_inc(upd_cnt_p0) : sat_dec(upd_cnt_p0);
    lkp_idx_p0 = lookup_pc[INDEX_W+1:2] ^ ghr_ext;
    lkp_cnt_p0 = (update_en && (update_index == lkp_idx_p0)) ? upd_val_p0
                                                             : cnt[lkp_idx_p0];
  end

  // Stage p1: counter writeback and registered prediction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= INIT;
      vld_p1  <= 1'b0;
      pred_p1 <= 1'b0;
      idx_p1  <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= INIT;
      vld_p1 <= 1'b0;
    end else begin
      if (update_en) cnt[update_index] <= upd_val_p0;
      vld_p1 <= lookup_en;
      if (lookup_en) begin
        pred_p1 <= lkp_cnt_p0[CNT_W-1];
        idx_p1  <= lkp_idx_p0;
      end
    end
  end

  assign predict_valid = vld_p1;
  assign predict       = pred_p1;
  assign predict_index = idx_p1;

endmodule
